// File: rtl/dmem_port_arbiter.sv
// Arbitrates the load path and the committed-store path onto a single data-memory port.
// Requests are issued as one-cycle mask pulses; the port is held until dmem_resp returns.
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TAG_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [31:0]      ld_addr,
  input  logic [3:0]       ld_rmask,
  input  logic [TAG_W-1:0] ld_tag,
  output logic             ld_resp_valid,
  output logic [31:0]      ld_resp_rdata,
  output logic [TAG_W-1:0] ld_resp_tag,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [3:0]       st_wmask,
  input  logic [31:0]      st_wdata,
  output logic             st_resp_valid,
  output logic [31:0]      dmem_addr,
  output logic [3:0]       dmem_rmask,
  output logic [3:0]       dmem_wmask,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_resp,
  output logic             busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT} state_t;

  state_t           r_state;
  logic             r_first;
  logic             r_kill;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [31:0]      r_addr;
  logic [3:0]       r_rmask;
  logic [3:0]       r_wmask;
  logic [31:0]      r_wdata;
  logic [TAG_W-1:0] r_tag;

  logic w_idle;
  logic w_starved;
  logic w_ld_pick;
  logic w_ld_grant;
  logic w_st_grant;
  logic w_resp;

  always_comb begin
    w_idle     = (r_state == IDLE) && !rst;
    w_starved  = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
    // A flushed load is never grantable, so a waiting store wins even when starved.
    w_ld_pick  = ld_valid && !flush && (!st_valid || w_starved);
    w_ld_grant = w_idle && w_ld_pick;
    w_st_grant = w_idle && st_valid && !w_ld_pick;
    // Responses during the pulse cycle or while idle are strays.
    w_resp     = dmem_resp && !rst && !r_first && (r_state != IDLE);
  end

  assign ld_ready      = w_ld_grant;
  assign st_ready      = w_st_grant;
  assign ld_resp_valid = w_resp && (r_state == LOAD_WAIT) && !r_kill && !flush;
  assign ld_resp_rdata = ld_resp_valid ? dmem_rdata : 32'h0;
  assign ld_resp_tag   = r_tag;
  assign st_resp_valid = w_resp && (r_state == STORE_WAIT);
  assign dmem_addr     = r_addr;
  assign dmem_rmask    = r_rmask;
  assign dmem_wmask    = r_wmask;
  assign dmem_wdata    = r_wdata;
  assign busy          = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_first      <= 1'b0;
      r_kill       <= 1'b0;
      r_starve_cnt <= '0;
      r_addr       <= 32'h0;
      r_rmask      <= 4'h0;
      r_wmask      <= 4'h0;
      r_wdata      <= 32'h0;
      r_tag        <= '0;
    end else begin
      r_first <= 1'b0;
      r_rmask <= 4'h0;
      r_wmask <= 4'h0;
      case (r_state)
        IDLE: begin
          if (w_ld_grant) begin
            r_state      <= LOAD_WAIT;
            r_first      <= 1'b1;
            r_addr       <= ld_addr & ~32'h3;
            r_rmask      <= ld_rmask;
            r_tag        <= ld_tag;
            r_starve_cnt <= '0;
          end else if (w_st_grant) begin
            r_state <= STORE_WAIT;
            r_first <= 1'b1;
            r_addr  <= st_addr & ~32'h3;
            r_wmask <= st_wmask;
            r_wdata <= st_wdata;
            if (ld_valid && !flush && !w_starved)
              r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            else if (!ld_valid)
              r_starve_cnt <= '0;
          end else if (!ld_valid) begin
            r_starve_cnt <= '0;
          end
        end
        LOAD_WAIT: begin
          if (flush) r_kill <= 1'b1;
          if (w_resp) begin
            r_state <= IDLE;
            r_kill  <= 1'b0;
          end
        end
        STORE_WAIT: begin
          if (w_resp) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a randomized
// transaction run compared against a transaction-level arbitration model.
module tb_dmem_port_arbiter;
  localparam int LIMIT = 2;
  localparam int TW    = 5;

  logic          clk = 1'b0;
  logic          rst, flush, ld_valid, st_valid, dmem_resp;
  logic [31:0]   ld_addr, st_addr, st_wdata, dmem_rdata;
  logic [3:0]    ld_rmask, st_wmask;
  logic [TW-1:0] ld_tag;
  logic          ld_ready, st_ready, ld_resp_valid, st_resp_valid, busy;
  logic [31:0]   ld_resp_rdata, dmem_addr, dmem_wdata;
  logic [TW-1:0] ld_resp_tag;
  logic [3:0]    dmem_rmask, dmem_wmask;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_port_arbiter #(.STARVE_LIMIT(LIMIT), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_rmask(ld_rmask), .ld_tag(ld_tag),
    .ld_resp_valid(ld_resp_valid), .ld_resp_rdata(ld_resp_rdata), .ld_resp_tag(ld_resp_tag),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_wmask(st_wmask), .st_wdata(st_wdata),
    .st_resp_valid(st_resp_valid),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    flush = 0; ld_valid = 0; st_valid = 0; dmem_resp = 0;
    ld_addr = 0; ld_rmask = 0; ld_tag = 0; st_addr = 0; st_wmask = 0; st_wdata = 0; dmem_rdata = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs(); ld_valid = 1; st_valid = 1;
    sample();
    n_checks++; if ({ld_ready, st_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {ld_ready, st_ready}); end
    step(); clear_inputs(); step(); rst = 0;
    sample();
    n_checks++; if ({dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, busy} !== '0) begin n_fail++; $display("FAIL reset_regs: addr=%h rm=%h wm=%h wd=%h busy=%b want all 0", dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, busy); end
    n_checks++; if ({ld_resp_valid, ld_resp_rdata, ld_resp_tag, st_resp_valid} !== '0) begin n_fail++; $display("FAIL reset_resp: lrv=%b rd=%h tag=%0d srv=%b want 0", ld_resp_valid, ld_resp_rdata, ld_resp_tag, st_resp_valid); end
    step();
  endtask

  task automatic test_single_load();
    ld_valid = 1; ld_addr = 32'h1000_0006; ld_rmask = 4'b1100; ld_tag = 3;
    sample();
    n_checks++; if ({ld_ready, st_ready} !== 2'b10) begin n_fail++; $display("FAIL sl_grant: got %b want 10", {ld_ready, st_ready}); end
    step(); ld_valid = 0;
    sample();
    n_checks++; if (dmem_addr !== 32'h1000_0004 || dmem_rmask !== 4'b1100 || busy !== 1'b1) begin n_fail++; $display("FAIL sl_pulse: addr=%h rm=%b busy=%b want 10000004 1100 1", dmem_addr, dmem_rmask, busy); end
    step();
    sample();
    n_checks++; if (dmem_rmask !== 4'b0000 || dmem_addr !== 32'h1000_0004 || ld_resp_valid !== 1'b0) begin n_fail++; $display("FAIL sl_hold: rm=%b addr=%h lrv=%b want 0000 10000004 0", dmem_rmask, dmem_addr, ld_resp_valid); end
    step(); dmem_resp = 1; dmem_rdata = 32'hDEAD_BEEF;
    sample();
    n_checks++; if (ld_resp_valid !== 1'b1 || ld_resp_rdata !== 32'hDEAD_BEEF || ld_resp_tag !== TW'(3)) begin n_fail++; $display("FAIL sl_resp: v=%b rd=%h tag=%0d want 1 deadbeef 3", ld_resp_valid, ld_resp_rdata, ld_resp_tag); end
    step(); dmem_resp = 0;
    sample();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sl_busy_done: got %b want 0", busy); end
    step();
  endtask

  task automatic test_simultaneous();
    ld_valid = 1; ld_addr = 32'h0000_0040; ld_rmask = 4'hF; ld_tag = 7;
    st_valid = 1; st_addr = 32'h2000_0000; st_wmask = 4'hF; st_wdata = 32'h1234_5678;
    sample();
    n_checks++; if ({ld_ready, st_ready} !== 2'b01) begin n_fail++; $display("FAIL sim_grant: got %b want 01", {ld_ready, st_ready}); end
    step(); st_valid = 0;
    sample();
    n_checks++; if (dmem_wmask !== 4'hF || dmem_wdata !== 32'h1234_5678 || dmem_addr !== 32'h2000_0000 || dmem_rmask !== 4'h0 || ld_ready !== 1'b0) begin n_fail++; $display("FAIL sim_pulse: wm=%h wd=%h addr=%h rm=%h lr=%b", dmem_wmask, dmem_wdata, dmem_addr, dmem_rmask, ld_ready); end
    step(); dmem_resp = 1;
    sample();
    n_checks++; if (st_resp_valid !== 1'b1 || ld_ready !== 1'b0 || ld_resp_valid !== 1'b0) begin n_fail++; $display("FAIL sim_st_resp: srv=%b lr=%b lrv=%b want 1 0 0", st_resp_valid, ld_ready, ld_resp_valid); end
    step(); dmem_resp = 0;
    sample();
    n_checks++; if ({ld_ready, st_ready} !== 2'b10) begin n_fail++; $display("FAIL sim_ld_next: got %b want 10", {ld_ready, st_ready}); end
    step(); ld_valid = 0;
    step(); dmem_resp = 1;
    sample();
    n_checks++; if (ld_resp_valid !== 1'b1 || ld_resp_tag !== TW'(7)) begin n_fail++; $display("FAIL sim_ld_resp: v=%b tag=%0d want 1 7", ld_resp_valid, ld_resp_tag); end
    step(); dmem_resp = 0; step();
  endtask

  task automatic test_starvation();
    string got = "";
    ld_valid = 1; ld_addr = 32'h300; ld_rmask = 4'h1; ld_tag = 1;
    st_valid = 1; st_addr = 32'h400; st_wmask = 4'h3; st_wdata = 32'hA5A5_A5A5;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (ld_ready && !st_ready) got = {got, "L"};
      else if (st_ready && !ld_ready) got = {got, "S"};
      else got = {got, "?"};
      step(); step(); dmem_resp = 1;
      step(); dmem_resp = 0;
      if (i == 5) begin ld_valid = 0; st_valid = 0; end
    end
    n_checks++; if (got != "SSLSSL") begin n_fail++; $display("FAIL starve_order: got %s want SSLSSL", got); end
    step();
  endtask

  task automatic test_flush_wait();
    ld_valid = 1; ld_addr = 32'h500; ld_rmask = 4'hF; ld_tag = 9;
    sample();
    n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL fw_grant: got %b want 1", ld_ready); end
    step(); ld_valid = 0; st_valid = 1; st_addr = 32'h600; st_wmask = 4'h8; st_wdata = 32'h0BAD_F00D;
    sample();
    n_checks++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL fw_st_blocked: got %b want 0", st_ready); end
    step(); flush = 1;
    step(); flush = 0;
    step(); dmem_resp = 1; dmem_rdata = 32'hFFFF_0000;
    sample();
    n_checks++; if (ld_resp_valid !== 1'b0) begin n_fail++; $display("FAIL fw_killed: got %b want 0", ld_resp_valid); end
    step(); dmem_resp = 0;
    sample();
    n_checks++; if (busy !== 1'b0 || st_ready !== 1'b1) begin n_fail++; $display("FAIL fw_after: busy=%b sr=%b want 0 1", busy, st_ready); end
    step(); st_valid = 0;
    step(); dmem_resp = 1;
    sample();
    n_checks++; if (st_resp_valid !== 1'b1 || ld_resp_valid !== 1'b0) begin n_fail++; $display("FAIL fw_st_resp: srv=%b lrv=%b want 1 0", st_resp_valid, ld_resp_valid); end
    step(); dmem_resp = 0; step();
  endtask

  task automatic test_flush_coincident();
    ld_valid = 1; ld_addr = 32'h700; ld_rmask = 4'h2; ld_tag = 4;
    step(); ld_valid = 0;
    step(); flush = 1; dmem_resp = 1; dmem_rdata = 32'h1111_2222;
    sample();
    n_checks++; if (ld_resp_valid !== 1'b0) begin n_fail++; $display("FAIL fc_resp: got %b want 0", ld_resp_valid); end
    step(); dmem_resp = 0; ld_valid = 1; flush = 1;
    sample();
    n_checks++; if (ld_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL fc_idle_flush: lr=%b busy=%b want 0 0", ld_ready, busy); end
    step(); ld_valid = 0; flush = 0;
    sample();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fc_no_txn: busy=%b want 0", busy); end
    step();
  endtask

  task automatic test_reset_mid_store();
    st_valid = 1; st_addr = 32'h800; st_wmask = 4'hC; st_wdata = 32'hCAFE_CAFE;
    step(); st_valid = 0;
    step(); rst = 1;
    step(); rst = 0; dmem_resp = 1;
    sample();
    n_checks++; if ({dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, busy, ld_ready, st_ready} !== '0) begin n_fail++; $display("FAIL rms_regs: addr=%h wm=%h wd=%h busy=%b want 0", dmem_addr, dmem_wmask, dmem_wdata, busy); end
    n_checks++; if ({st_resp_valid, ld_resp_valid} !== 2'b00) begin n_fail++; $display("FAIL rms_late_resp: srv=%b lrv=%b want 0 0", st_resp_valid, ld_resp_valid); end
    step(); dmem_resp = 0; step();
  endtask

  // Model: stores win unless LIMIT consecutive stores were granted while a load waited.
  task automatic test_random();
    int m_cnt = 0;
    for (int n = 0; n < 80; n++) begin
      bit lv, sv, exp_ld, exp_st;
      logic [31:0] a, wd, rd;
      logic [3:0] m;
      logic [TW-1:0] tg;
      int lat;
      lv = 1'($urandom_range(0, 1)); sv = 1'($urandom_range(0, 1));
      a = $urandom; wd = $urandom; m = 4'($urandom_range(1, 15)); tg = TW'($urandom_range(0, 31));
      ld_valid = lv; ld_addr = a; ld_rmask = m; ld_tag = tg;
      st_valid = sv; st_addr = a; st_wmask = m; st_wdata = wd;
      exp_ld = lv && (!sv || m_cnt == LIMIT);
      exp_st = sv && !exp_ld;
      if (!lv || exp_ld) m_cnt = 0;
      else if (m_cnt < LIMIT) m_cnt++;
      sample();
      n_checks++; if ({ld_ready, st_ready, busy} !== {exp_ld, exp_st, 1'b0}) begin n_fail++; $display("FAIL rnd_grant[%0d]: lr/sr/busy=%b%b%b want %b%b0", n, ld_ready, st_ready, busy, exp_ld, exp_st); end
      step(); ld_valid = 0; st_valid = 0;
      if (!exp_ld && !exp_st) continue;
      dmem_resp = 1'($urandom_range(0, 1));
      sample();
      n_checks++; if (busy !== 1'b1 || dmem_addr !== (a & ~32'h3) || dmem_rmask !== (exp_ld ? m : 4'h0) || dmem_wmask !== (exp_st ? m : 4'h0) || (exp_st && dmem_wdata !== wd) || ld_resp_valid || st_resp_valid) begin
        n_fail++; $display("FAIL rnd_pulse[%0d]: addr=%h rm=%h wm=%h wd=%h lrv=%b srv=%b want addr=%h m=%h", n, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, ld_resp_valid, st_resp_valid, a & ~32'h3, m);
      end
      lat = $urandom_range(1, 3);
      for (int k = 1; k < lat; k++) begin
        step(); dmem_resp = 0;
        sample();
        n_checks++; if ({dmem_rmask, dmem_wmask, ld_resp_valid, st_resp_valid} !== '0 || dmem_addr !== (a & ~32'h3)) begin n_fail++; $display("FAIL rnd_wait[%0d]: rm=%h wm=%h lrv=%b srv=%b addr=%h", n, dmem_rmask, dmem_wmask, ld_resp_valid, st_resp_valid, dmem_addr); end
      end
      step(); rd = $urandom; dmem_rdata = rd; dmem_resp = 1;
      sample();
      n_checks++; if (ld_resp_valid !== exp_ld || st_resp_valid !== exp_st || (exp_ld && (ld_resp_rdata !== rd || ld_resp_tag !== tg))) begin
        n_fail++; $display("FAIL rnd_resp[%0d]: lrv=%b srv=%b rd=%h tag=%0d want %b %b %h %0d", n, ld_resp_valid, st_resp_valid, ld_resp_rdata, ld_resp_tag, exp_ld, exp_st, rd, tg);
      end
      step(); dmem_resp = 0;
    end
    sample();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_end_busy: got %b want 0", busy); end
    step();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    step();
    test_reset();
    test_single_load();
    test_simultaneous();
    test_starvation();
    test_flush_wait();
    test_flush_coincident();
    test_reset_mid_store();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Single-port data-memory controller sitting between the load path and the committed-store path of the out-of-order core and the one `dmem_*` port. It accepts one request at a time from either requester and issues it to memory as a one-cycle request pulse. It then holds the port until `dmem_resp` arrives and routes the response back. Stores win by default, with a starvation limit that guarantees loads progress. Loads in flight during a pipeline flush are silently drained.

## Interface
- `STARVE_LIMIT`, default 4: consecutive store grants, made while a load is waiting, after which the next grant goes to the load.
- `TAG_W`, default 5: width of the load tag (ROB index).
- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-high
- `flush`  in  1  kill the in-flight or pending load; stores are unaffected
- `ld_valid`  in  1  load request pending
- `ld_ready`  out  1  load accepted this cycle (combinational)
- `ld_addr`  in  32  byte address
- `ld_rmask`  in  4  byte-lane read mask, already lane-shifted by the requester
- `ld_tag`  in  TAG_W  tag returned with the load response
- `ld_resp_valid`  out  1  load data valid (one cycle)
- `ld_resp_rdata`  out  32  raw word from memory; the requester does lane extraction
- `ld_resp_tag`  out  TAG_W  tag of the accepted load
- `st_valid`  in  1  committed store pending
- `st_ready`  out  1  store accepted this cycle (combinational)
- `st_addr`  in  32  byte address
- `st_wmask`  in  4  byte-lane write mask
- `st_wdata`  in  32  write data, lane-aligned
- `st_resp_valid`  out  1  store completed (one cycle)
- `dmem_addr`  out  32  word-aligned address `{addr[31:2],2'b00}`
- `dmem_rmask`  out  4  read mask
- `dmem_wmask`  out  4  write mask
- `dmem_wdata`  out  32  write data
- `dmem_rdata`  in  32  read data
- `dmem_resp`  in  1  memory response
- `busy`  out  1  state is not IDLE

## Operation
- **States:** IDLE, LOAD_WAIT, STORE_WAIT.
- **IDLE:**
  - Grant goes to the store if `st_valid`, unless `starve_cnt == STARVE_LIMIT` and `ld_valid`; in that case grant goes to the load.
  - A load is grantable only when `!flush`.
  - Grant asserts the matching `*_ready` in the same cycle.
  - The request is latched, and the state moves to LOAD_WAIT or STORE_WAIT.
- **Starvation counter:**
  - Increments, saturating at `STARVE_LIMIT`, on a store grant while `ld_valid && !flush`.
  - Clears on a load grant, or in IDLE when `!ld_valid`.
- **Request pulse:**
  - `dmem_rmask` or `dmem_wmask` is nonzero for exactly the first cycle in a WAIT state, and zero otherwise.
  - `dmem_addr` and `dmem_wdata` hold their latched values through the entire WAIT state.
- **LOAD_WAIT:**
  - On `dmem_resp`: `ld_resp_valid = !kill && !flush`, with `ld_resp_rdata = dmem_rdata` and `ld_resp_tag = latched tag`, same cycle.
  - Next state is IDLE; `kill` clears.
- **Load kill:** `flush` while in LOAD_WAIT sets `kill`. The eventual response is consumed without `ld_resp_valid`.
- **STORE_WAIT:** On `dmem_resp`, `st_resp_valid = 1` in the same cycle; next state is IDLE. `flush` is ignored.
- **Stray responses:** `dmem_resp` in IDLE, or in the first WAIT cycle (the request-pulse cycle), is ignored. The memory model's minimum latency is 1 cycle after the pulse.
- **Reset values:**
  - State IDLE; `starve_cnt` = 0; `kill` = 0.
  - All outputs 0: `dmem_addr`, `dmem_rmask`, `dmem_wmask`, `dmem_wdata`, `ld_ready`, `st_ready`, `ld_resp_*`, `st_resp_valid`, `busy`.
- **Reset mid-transaction:** The transaction is abandoned with no response emitted. A later `dmem_resp` is ignored in IDLE.

## Timing
- **Grant:** Accept at cycle T, so `*_ready` = 1 at T.
- **Request pulse:** Mask pulse at T+1; `busy` = 1 from T+1.
- **Response:** `dmem_resp` at R ≥ T+2 gives the response output at R; `busy` = 0 at R+1.
- **Next grant:** Earliest at R+1, with its pulse at R+2. Peak throughput is one access per (memory latency + 2) cycles.
- **Outputs:** `ld_ready` and `st_ready` are never both 1. The response outputs are combinational from `dmem_resp` and registered state. All other outputs are registered.

## Test plan
- **Single load:**
  - Stimulus: `ld_valid` at T with `ld_addr = 0x1000_0006`, `ld_rmask = 4'b1100`, `ld_tag = 3`; `dmem_resp` at T+3 with `dmem_rdata = 0xDEADBEEF`.
  - Expect: `ld_ready` at T; `dmem_addr = 0x1000_0004` and `dmem_rmask = 4'b1100` at T+1 only.
  - Expect: `ld_resp_valid` at T+3 with `0xDEADBEEF`, tag 3; `busy` = 0 at T+4.
- **Simultaneous requests:**
  - Stimulus: `ld_valid` and `st_valid` both at T, with `st_addr = 0x2000_0000`, `st_wmask = 4'hF`, `st_wdata = 0x12345678`.
  - Expect: store granted at T; `wmask = 4'hF` and wdata `0x12345678` at T+1; `st_resp_valid` at resp.
  - Expect: load granted on the cycle after the store response.
- **Starvation, `STARVE_LIMIT = 2`:**
  - Stimulus: `st_valid` and `ld_valid` held continuously.
  - Expect: grant order store, store, load, store, store, load.
- **Flush in LOAD_WAIT:**
  - Stimulus: `flush` at T+2 of a load accepted at T; `dmem_resp` at T+4.
  - Expect: `ld_resp_valid` stays 0; `busy` = 0 at T+5; a pending store is granted at T+5.
- **Flush coincident with response:**
  - Stimulus: `flush` and `dmem_resp` in the same cycle of LOAD_WAIT.
  - Expect: no `ld_resp_valid`.
  - Stimulus: `flush` in IDLE with `ld_valid`.
  - Expect: `ld_ready` = 0 that cycle.
- **Reset mid-store:**
  - Stimulus: `rst` during STORE_WAIT; `dmem_resp` one cycle after reset deasserts.
  - Expect: all outputs 0 in the cycle after reset.
  - Expect: the late `dmem_resp` is ignored, with `st_resp_valid` = 0.
